// File: rtl/tmds_pixel_encoder.sv
// Three-channel DVI TMDS encoder: input register, transition-minimising stage,
// then DC-balancing stage with a per-channel running-disparity register.
`timescale 1ns/1ps

module tmds_pixel_encoder (
    input  logic              clkPixel,
    input  logic              reset,
    input  logic [7:0]        rIn,
    input  logic [7:0]        gIn,
    input  logic [7:0]        bIn,
    input  logic              blank,
    input  logic              hsync,
    input  logic              vsync,
    output logic [9:0]        tmdsR,
    output logic [9:0]        tmdsG,
    output logic [9:0]        tmdsB,
    output logic signed [4:0] dispR,
    output logic signed [4:0] dispG,
    output logic signed [4:0] dispB
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;

    function automatic logic [3:0] f_ones(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

    function automatic logic [8:0] f_stage1(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = f_ones(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] f_ctrl(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Channel index: 0 = blue, 1 = green, 2 = red.
    logic [7:0] r_din [3];
    logic       r_in_blank;
    logic [1:0] r_in_c;
    logic [8:0] r_qm [3];
    logic       r_s1_blank;
    logic [1:0] r_s1_c;

    always_ff @(posedge clkPixel) begin
        if (reset) begin
            r_in_blank <= 1'b1;
            r_in_c     <= 2'b00;
            r_s1_blank <= 1'b1;
            r_s1_c     <= 2'b00;
            for (int k = 0; k < 3; k++) begin
                r_din[k] <= '0;
                r_qm[k]  <= '0;
            end
        end else begin
            r_din[0]   <= bIn;
            r_din[1]   <= gIn;
            r_din[2]   <= rIn;
            r_in_blank <= blank;
            r_in_c     <= {vsync, hsync};
            r_s1_blank <= r_in_blank;
            r_s1_c     <= r_in_c;
            for (int k = 0; k < 3; k++) r_qm[k] <= f_stage1(r_din[k]);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_chan
        logic [9:0]        r_tmds;
        logic signed [4:0] r_cnt;
        logic [7:0]        w_q;
        logic              w_q8;
        logic [1:0]        w_c;
        logic signed [4:0] w_diff;
        logic              w_cnt_pos;
        logic              w_cnt_neg;
        logic              w_more1;
        logic              w_more0;
        logic [9:0]        w_sym;
        logic signed [4:0] w_cnt_next;

        assign w_q       = r_qm[g][7:0];
        assign w_q8      = r_qm[g][8];
        assign w_c       = (g == 0) ? r_s1_c : 2'b00;
        // w_diff = n1 - n0 = 2*n1 - 8; modulo-32 arithmetic lands on the exact value.
        assign w_diff    = $signed({f_ones(w_q), 1'b0} - 5'd8);
        assign w_cnt_neg = r_cnt[4];
        assign w_cnt_pos = !r_cnt[4] && (r_cnt != 5'sd0);
        assign w_more0   = w_diff[4];
        assign w_more1   = !w_diff[4] && (w_diff != 5'sd0);

        always_comb begin
            // NOTE: defaults first so every path assigns both outputs; no latch.
            w_sym      = f_ctrl(w_c);
            w_cnt_next = 5'sd0;
            if (!r_s1_blank) begin
                if ((r_cnt == 5'sd0) || (w_diff == 5'sd0)) begin
                    w_sym      = {~w_q8, w_q8, w_q8 ? w_q : ~w_q};
                    w_cnt_next = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
                end else if ((w_cnt_pos && w_more1) || (w_cnt_neg && w_more0)) begin
                    w_sym      = {1'b1, w_q8, ~w_q};
                    w_cnt_next = r_cnt - w_diff + (w_q8 ? 5'sd2 : 5'sd0);
                end else begin
                    w_sym      = {1'b0, w_q8, w_q};
                    w_cnt_next = r_cnt + w_diff - (w_q8 ? 5'sd0 : 5'sd2);
                end
            end
        end

        always_ff @(posedge clkPixel) begin
            if (reset) begin
                r_tmds <= CTRL_00;
                r_cnt  <= 5'sd0;
            end else begin
                r_tmds <= w_sym;
                r_cnt  <= w_cnt_next;
            end
        end
    end

    assign tmdsB = g_chan[0].r_tmds;
    assign tmdsG = g_chan[1].r_tmds;
    assign tmdsR = g_chan[2].r_tmds;
    assign dispB = g_chan[0].r_cnt;
    assign dispG = g_chan[1].r_cnt;
    assign dispR = g_chan[2].r_cnt;

endmodule

// File: doc/tmds_pixel_encoder.md
# tmds_pixel_encoder

Three-channel DVI/HDMI TMDS encoder for the FSX video path. Takes the 8-bit-per-channel RGB bytes, blank, hsync and vsync produced by the frame synthesizer on the pixel clock and emits one 10-bit TMDS symbol per channel per cycle. It applies DVI 1.0 transition minimisation and running-disparity DC balancing. Output feeds the 10:1 serializer/LVDS stage.

## Interface
- Parameters: none.
- clkPixel  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- rIn  in  8  red byte
- gIn  in  8  green byte
- bIn  in  8  blue byte
- blank  in  1  1 = outside active area; control period
- hsync  in  1  horizontal sync, carried as c0 on blue channel
- vsync  in  1  vertical sync, carried as c1 on blue channel
- tmdsR  out  10  red symbol (channel 2), bit 0 transmitted first
- tmdsG  out  10  green symbol (channel 1)
- tmdsB  out  10  blue symbol (channel 0)
- dispR, dispG, dispB  out  5  signed running disparity after current symbol (verification visibility)

## Operation
- Three identical channel encoders; control inputs {c1,c0}: blue = {vsync,hsync}, green = 00, red = 00.
- Stage 1 (per channel), on registered input D: N1 = popcount(D). Use XNOR if N1>4 or (N1==4 and D[0]==0), else XOR. q_m[0]=D[0]; q_m[i]=q_m[i-1] op D[i], i=1..7; q_m[8]=0 for XNOR, 1 for XOR. Register q_m, blank, c1, c0.
- Stage 2: n1=popcount(q_m[7:0]), n0=8-n1; cnt = channel disparity register (5-bit signed, two's complement).
- blank=1: output control code, cnt <= 0. Codes: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- blank=0, case A (cnt==0 or n1==n0): out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt += q_m[8] ? (n1-n0) : (n0-n1).
- case B ((cnt>0 and n1>n0) or (cnt<0 and n0>n1)): out={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (n0-n1).
- case C (otherwise): out={0, q_m[8], q_m[7:0]}; cnt += (n1-n0) - 2*(~q_m[8]).
- All disparity arithmetic in 5-bit signed; legal range stays within -10..+10, so no wrap. Channels are independent; no inter-channel state.

## Timing
- Latency: inputs sampled at edge N appear on tmds* after edge N+2 (input reg, stage-1 reg, output reg); fixed, no bubbles, no handshake. Sync, blank and data stay aligned.
- disp* updates on the same edge as the corresponding symbol.
- Reset: at the reset edge all pipeline registers are cleared to blank=1, c=00; tmdsR/G/B = 1101010100, disp* = 0. This holds for as long as reset is held. After reset deasserts, the first input sample reaches the output on the 3rd edge. During the two cycles before that, the output continues as the 00 control code.
- Reset mid-frame: any in-flight symbols are discarded and disparity is zeroed in the same cycle.
- A blank→active transition mid-stream begins data encoding with cnt=0 (cleared by the preceding blank cycle).
- A blank=1 cycle always clears cnt, even when it is a single isolated cycle.

## Test plan
- Reset: hold reset 3 cycles with arbitrary inputs → every channel outputs 0x354 (1101010100), disp=0; release → same until the first sample emerges after 3 edges.
- Control codes: blank=1, {vsync,hsync} stepped 00,01,10,11 → tmdsB = 0x354, 0x0AB, 0x154, 0x2AB with 2-cycle latency; tmdsR/G stay 0x354.
- Constant 0x00 active data on all channels after blank → symbols 0x100, 0x3FF, 0x100, 0x3FF… with disp −8, 2, −6, 4, −4, 6, −2, 8, 0.
- 0xFF after blank → first symbol 0x200, disp −8; XNOR path (q_m[8]=0) is checked.
- Random RGB for 10k pixels with random blank bursts → output matches the reference model bit-exactly; disp stays in −10..10; every 10-bit symbol decodes back to its input byte.
- Assert reset in the middle of an active run with disp≠0 → the next output is 0x354 and disp=0; no stale data symbol appears after release.
